inst_fetch: RTL and testbench

- IF stage of the RV32I core. Holds the program counter and drives the combinational instruction ROM address.
- Registers the returned instruction word and its PC into an IF/ID output register, which a valid/ready handshake presents to the decoder.
- Accepts a redirect (taken branch, jal, jalr) from execute. A redirect flushes the in-flight word and restarts fetch at the target.

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/inst_fetch_if.sv | 28 ++
 rtl/pc_gen.sv | 29 ++
 rtl/inst_fetch.sv | 86 ++++++++
 tb/tb_inst_fetch.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: architectural constants, reset/NOP values and the
// base opcode map used by the fetch and decode stages.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int PC_STEP_DEFAULT = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: redirect from execute, ROM port, IF/ID handshake and status.
// The slave modport is the fetch stage; master is its environment.
interface inst_fetch_if;
  import rv32i_pkg::*;

  logic            iFetchEn;
  logic            iRedirect;
  logic [XLEN-1:0] iRedirectPc;
  logic [XLEN-1:0] oImemAddr;
  logic [XLEN-1:0] iImemData;
  logic            oIfValid;
  logic            iIdReady;
  logic [XLEN-1:0] oIfInst;
  logic [XLEN-1:0] oIfPc;
  logic            oMisalign;
  logic [XLEN-1:0] oFetchCnt;

  modport slave (
    input  iFetchEn, iRedirect, iRedirectPc, iImemData, iIdReady,
    output oImemAddr, oIfValid, oIfInst, oIfPc, oMisalign, oFetchCnt
  );

  modport master (
    output iFetchEn, iRedirect, iRedirectPc, iImemData, iIdReady,
    input  oImemAddr, oIfValid, oIfInst, oIfPc, oMisalign, oFetchCnt
  );

endinterface

// File: rtl/pc_gen.sv
// Next-PC selection for the fetch stage: redirect beats sequential step beats hold.
// Redirect targets are forced word-aligned; the dropped low bits raise misalign.
module pc_gen
  import rv32i_pkg::*;
#(
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            load_i,
  output logic [XLEN-1:0] pc_d_o,
  output logic            misalign_o
);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    pc_d_o = pc_i;
    if (redirect_i) begin
      pc_d_o = align_word(redirect_pc_i);
    end else if (load_i) begin
      pc_d_o = pc_i + XLEN'(PC_STEP);  // wraps modulo 2^32 by width
    end
  end

  assign misalign_o = redirect_i & (|redirect_pc_i[1:0]);

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction fetch: PC register, combinational ROM address and an IF/ID
// output register presented to decode over a valid/ready handshake.
module inst_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input logic         iClk,
  input logic         iRst_n,
  inst_fetch_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic load;
  logic handoff;

  // A word may be loaded when the output register is empty or being drained.
  assign load    = bus.iFetchEn & (~valid_q | bus.iIdReady);
  assign handoff = valid_q & bus.iIdReady;

  pc_gen #(
    .PC_STEP(PC_STEP)
  ) u_pc_gen (
    .pc_i         (pc_q),
    .redirect_i   (bus.iRedirect),
    .redirect_pc_i(bus.iRedirectPc),
    .load_i       (load),
    .pc_d_o       (pc_d),
    .misalign_o   (misalign_d)
  );

  // Redirect squashes the register contents by clearing valid only; the word
  // and its PC are left in place so the outputs do not toggle needlessly.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    if_pc_d = if_pc_q;
    if (bus.iRedirect) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = bus.iImemData;
      if_pc_d = pc_q;
    end else if (handoff & ~bus.iFetchEn) begin
      valid_d = 1'b0;
    end
  end

  // A handoff coinciding with a redirect still counts: decode took that word.
  assign cnt_d = cnt_q + XLEN'(handoff);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      inst_q     <= NOP_INST;
      if_pc_q    <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      if_pc_q    <= if_pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.oImemAddr = pc_q;
  assign bus.oIfValid  = valid_q;
  assign bus.oIfInst   = inst_q;
  assign bus.oIfPc     = if_pc_q;
  assign bus.oMisalign = misalign_q;
  assign bus.oFetchCnt = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic, checked by a
// scoreboard holding the instruction stream decode is expected to accept.
module tb_inst_fetch;
  import rv32i_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic iClk = 1'b0;
  logic iRst_n;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC(RESET_PC),
    .PC_STEP (4)
  ) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  // Instruction ROM contents: two fixed words at 0/4, a hash everywhere else.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h002083B3;
    if (a == 32'd4) return 32'h41348233;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  assign bus.iImemData = rom_word(bus.oImemAddr);

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t        exp_q[$];
  logic [31:0] stream_pc;
  logic [31:0] exp_cnt;
  logic        mis_exp;
  logic        mon_en = 1'b0;
  logic        hold_prev;
  logic [31:0] prev_pc, prev_inst;
  int          stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decode sees consecutive words from the current stream
  // start; a redirect discards what is pending and starts a new stream.
  task automatic top_up();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc   = stream_pc;
      e.inst = rom_word(stream_pc);
      exp_q.push_back(e);
      stream_pc = stream_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    stream_pc = start;
    top_up();
  endtask

  task automatic model_reset();
    restart_stream(RESET_PC);
    exp_cnt   = 32'd0;
    mis_exp   = 1'b0;
    hold_prev = 1'b0;
    stall     = 0;
  endtask

  // One cycle of stimulus: drive at the falling edge, update the model once
  // the monitor has sampled this cycle, and return with outputs observable.
  task automatic cycle(input logic en, input logic rdy, input logic redir,
                       input logic [31:0] rpc);
    @(negedge iClk);
    bus.iFetchEn    = en;
    bus.iIdReady    = rdy;
    bus.iRedirect   = redir;
    bus.iRedirectPc = rpc;
    #3;
    mis_exp = redir & (|rpc[1:0]);
    if (redir) restart_stream({rpc[31:2], 2'b00});
    top_up();
  endtask

  task automatic run_until(input logic [31:0] tgt);
    int n = 0;
    do begin
      cycle(1'b1, 1'b1, 1'b0, $urandom());
      n++;
    end while (!(bus.oIfValid && bus.oIfPc == tgt) && n < 64);
    check("reach_pc", bus.oIfPc, tgt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    32'(bus.oIfValid),  32'd0);
    check({tag, "_inst"},     bus.oIfInst,        NOP_INST);
    check({tag, "_ifpc"},     bus.oIfPc,          32'd0);
    check({tag, "_misalign"}, 32'(bus.oMisalign), 32'd0);
    check({tag, "_cnt"},      bus.oFetchCnt,      32'd0);
    check({tag, "_imemaddr"}, bus.oImemAddr,      RESET_PC);
  endtask

  // Monitor: samples 2 time units after each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      #2;
      if (mon_en) begin
        check("misalign", 32'(bus.oMisalign), 32'(mis_exp));
        if (hold_prev) begin
          check("hold_valid", 32'(bus.oIfValid), 32'd1);
          check("hold_pc",    bus.oIfPc,         prev_pc);
          check("hold_inst",  bus.oIfInst,       prev_inst);
        end
        hold_prev = bus.oIfValid & ~bus.iIdReady & ~bus.iRedirect;
        prev_pc   = bus.oIfPc;
        prev_inst = bus.oIfInst;
        if (bus.oIfValid && bus.iIdReady) begin
          stall = 0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty: handoff pc %h with no expected word", bus.oIfPc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc",   bus.oIfPc,     e.pc);
            check("sb_inst", bus.oIfInst,   e.inst);
            check("sb_cnt",  bus.oFetchCnt, exp_cnt);
          end
          exp_cnt = exp_cnt + 32'd1;
        end else if (bus.iRedirect || !(bus.iFetchEn && bus.iIdReady)) begin
          stall = 0;
        end else begin
          stall++;
          if (stall > 2) begin
            n_cmp++;
            n_fail++;
            $display("FAIL stall_bound: %0d idle cycles with fetch enabled, limit 2", stall);
            stall = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt_ref;
    logic        en, rdy, redir;
    logic [31:0] tgt;

    bus.iFetchEn    = 1'b0;
    bus.iIdReady    = 1'b0;
    bus.iRedirect   = 1'b0;
    bus.iRedirectPc = 32'd0;
    iRst_n = 1'b1;
    #1 iRst_n = 1'b0;
    #1 check_reset_outputs("rst");

    // Reset release and straight-line fetch.
    @(negedge iClk);
    iRst_n = 1'b1;
    bus.iFetchEn = 1'b1;
    bus.iIdReady = 1'b1;
    model_reset();
    mon_en = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("e1_valid", 32'(bus.oIfValid), 32'd1);
    check("e1_inst",  bus.oIfInst,       32'h002083B3);
    check("e1_pc",    bus.oIfPc,         32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("e2_inst",  bus.oIfInst,       32'h41348233);
    check("e2_pc",    bus.oIfPc,         32'd4);
    check("e2_cnt",   bus.oFetchCnt,     32'd1);

    // Backpressure at PC 8.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("bp_pc0", bus.oIfPc, 32'd8);
    cnt_ref = bus.oFetchCnt;
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("bp_pc", bus.oIfPc, 32'd8);
    check("bp_addr", bus.oImemAddr, 32'd12);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("bp_cnt", bus.oFetchCnt, cnt_ref);
    check("bp_addr_hold", bus.oImemAddr, 32'd12);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("bp_release_pc", bus.oIfPc, 32'd12);

    // Redirect with simultaneous handoff at PC 156.
    run_until(32'd152);
    cycle(1'b1, 1'b1, 1'b1, 32'd160);
    check("rd_cur_pc", bus.oIfPc, 32'd156);
    cnt_ref = bus.oFetchCnt;
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    check("rd_bubble", 32'(bus.oIfValid), 32'd0);
    check("rd_cnt", bus.oFetchCnt, cnt_ref + 32'd1);
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    check("rd_tgt_valid", 32'(bus.oIfValid), 32'd1);
    check("rd_tgt_pc", bus.oIfPc, 32'd160);

    // Misaligned redirect.
    cycle(1'b1, 1'b1, 1'b1, 32'd170);
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    check("mis_pulse", 32'(bus.oMisalign), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    check("mis_clear", 32'(bus.oMisalign), 32'd0);
    check("mis_pc", bus.oIfPc, 32'd168);

    // Address wrap-around.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    check("wrap_pc_hi", bus.oIfPc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    check("wrap_pc_lo", bus.oIfPc, 32'd0);
    check("wrap_inst", bus.oIfInst, 32'h002083B3);

    // Asynchronous reset between edges at PC 40.
    cycle(1'b1, 1'b1, 1'b1, 32'd32);
    run_until(32'd40);
    mon_en = 1'b0;
    iRst_n = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge iClk);
    iRst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    check("post_rst_valid", 32'(bus.oIfValid), 32'd1);
    check("post_rst_pc", bus.oIfPc, RESET_PC);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 800; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 15) == 0);
      tgt   = $urandom();
      if ($urandom_range(0, 1) == 1) tgt[31:12] = 20'd0;
      cycle(en, rdy, redir, tgt);
    end
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    cycle(1'b1, 1'b1, 1'b0, $urandom());
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
